fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 103 ++++++++++
 tb/tb_fetch_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch FIFO with flush redirect; optional HLT stop under FQ_HALT_DETECT_EN
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic                     clk,
    input  logic                     rst_f,
    input  logic                     flush,
    input  logic [AW-1:0]            flush_addr,
    output logic [AW-1:0]            im_addr,
    input  logic [DW-1:0]            im_data,
    output logic [DW-1:0]            inst_out,
    output logic [AW-1:0]            inst_pc,
    output logic                     inst_valid,
    input  logic                     inst_pop,
`ifdef FQ_HALT_DETECT_EN
    output logic                     halted,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef FQ_HALT_DETECT_EN
    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
`else
    typedef enum logic {RUN, STALL} state_t;
`endif
    state_t state, state_n;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] word_q [DEPTH];
    logic [PW-1:0] hd, tl;
    logic [AW-1:0] fptr;
    logic full, pop, push;
`ifdef FQ_HALT_DETECT_EN
    logic hlt_push;
    assign push     = !flush && state != HALT && (!full || pop);
    assign hlt_push = push && im_data[DW-1:DW-4] == 4'hF;
    assign halted   = state == HALT;
`else
    assign push     = !flush && (!full || pop);
`endif
    assign full       = count == CW'(DEPTH);
    assign inst_valid = count != '0;
    assign pop        = inst_pop && inst_valid;
    assign im_addr    = fptr;
    assign inst_out   = inst_valid ? word_q[hd] : '0;
    assign inst_pc    = inst_valid ? addr_q[hd] : '0;

    // Fetch FSM next state: flush always returns to RUN, a queued HLT parks fetching
    always_comb begin
        state_n = state;
        if (flush)
            state_n = RUN;
`ifdef FQ_HALT_DETECT_EN
        else if (hlt_push)
            state_n = HALT;
`endif
        else if (state == RUN && full && !pop)
            state_n = STALL;
        else if (state == STALL && pop)
            state_n = RUN;
    end

    // Fetch FSM state register
    always_ff @(posedge clk) begin
        if (rst_f)
            state <= RUN;
        else
            state <= state_n;
    end

    // Queue storage; entries are only visible through count, so no reset needed
    always_ff @(posedge clk) begin
        if (!rst_f && push) begin
            addr_q[tl] <= fptr;
            word_q[tl] <= im_data;
        end
    end

    // Pointers and occupancy; flush empties the queue and redirects fetch
    always_ff @(posedge clk) begin
        if (rst_f) begin
            fptr  <= '0;
            hd    <= '0;
            tl    <= '0;
            count <= '0;
        end else if (flush) begin
            fptr  <= flush_addr;
            hd    <= '0;
            tl    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tl   <= tl + PW'(1);
                fptr <= fptr + AW'(1);
            end
            if (pop)
                hd <= hd + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector table, HLT sequence and random run against a queue-based reference model
module tb_fetch_queue;
    logic        clk;
    logic        rst_f;
    logic        flush;
    logic [15:0] flush_addr;
    logic [15:0] im_addr;
    logic [31:0] im_data;
    logic [31:0] inst_out;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_pop;
    logic [2:0]  count;
`ifdef FQ_HALT_DETECT_EN
    logic        halted;
`endif
    int          mode;
    int          tests;
    int          fails;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        r;
        logic        f;
        logic [15:0] fa;
        logic        p;
        logic [2:0]  cnt;
        logic [15:0] ia;
        logic        v;
        logic [31:0] out;
        logic [15:0] pc;
    } vec_t;

    ent_t        mq[$];
    int unsigned mf;
    bit          mh;
    vec_t        tbl[$];

    fetch_queue dut (
        .clk(clk),
        .rst_f(rst_f),
        .flush(flush),
        .flush_addr(flush_addr),
        .im_addr(im_addr),
        .im_data(im_data),
        .inst_out(inst_out),
        .inst_pc(inst_pc),
        .inst_valid(inst_valid),
        .inst_pop(inst_pop),
`ifdef FQ_HALT_DETECT_EN
        .halted(halted),
`endif
        .count(count)
    );

    function automatic logic [31:0] word(input int m, input logic [15:0] a);
        if (m == 1)
            return {4'h2, a[11:0] ^ 12'hA5C, a};
        if (m == 2 && a == 16'h0002)
            return 32'hF000_0000;
        return 32'h1000_0000 + {16'h0, a};
    endfunction

    assign im_data = word(mode, im_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic f, logic [15:0] fa, logic p, logic [2:0] cnt,
                                logic [15:0] ia, logic v, logic [31:0] out, logic [15:0] pc);
        vec_t t;
        t.r = r; t.f = f; t.fa = fa; t.p = p; t.cnt = cnt; t.ia = ia; t.v = v; t.out = out; t.pc = pc;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic void mstep(logic r, logic f, logic [15:0] fa, logic p);
        if (r) begin
            mq.delete();
            mf = 0;
            mh = 0;
        end else if (f) begin
            mq.delete();
            mf = fa;
            mh = 0;
        end else begin
            bit pp;
            bit pu;
            logic [31:0] w;
            pp = p && mq.size() > 0;
            pu = !mh && (mq.size() < 4 || pp);
            w = word(mode, mf[15:0]);
            if (pp)
                void'(mq.pop_front());
            if (pu) begin
                mq.push_back({mf[15:0], w});
                mf = (mf + 1) % 65536;
`ifdef FQ_HALT_DETECT_EN
                if (w[31:28] == 4'hF)
                    mh = 1;
`endif
            end
        end
    endfunction

    task automatic step(input logic r, input logic f, input logic [15:0] fa, input logic p);
        rst_f = r;
        flush = f;
        flush_addr = fa;
        inst_pop = p;
        mstep(r, f, fa, p);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string n);
        chk({n, ".count"}, 32'(count), 32'(mq.size()));
        chk({n, ".im_addr"}, 32'(im_addr), mf);
        chk({n, ".valid"}, 32'(inst_valid), 32'(mq.size() != 0));
        chk({n, ".out"}, inst_out, mq.size() != 0 ? mq[0].d : 32'h0);
        chk({n, ".pc"}, 32'(inst_pc), mq.size() != 0 ? 32'(mq[0].a) : 32'h0);
`ifdef FQ_HALT_DETECT_EN
        chk({n, ".halted"}, 32'(halted), 32'(mh));
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        mode = 0;
        mf = 0;
        mh = 0;
        rst_f = 1'b1;
        flush = 1'b0;
        flush_addr = 16'h0;
        inst_pop = 1'b0;

        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0, 16'h0000));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 32'h0, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0001, 1, 32'h1000_0000, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 2, 16'h0002, 1, 32'h1000_0000, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 3, 16'h0003, 1, 32'h1000_0000, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 4, 16'h0004, 1, 32'h1000_0000, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 4, 16'h0004, 1, 32'h1000_0000, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 4, 16'h0005, 1, 32'h1000_0001, 16'h0001));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 4, 16'h0006, 1, 32'h1000_0002, 16'h0002));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 4, 16'h0007, 1, 32'h1000_0003, 16'h0003));
        tbl.push_back(mk(0, 1, 16'h0020, 0, 0, 16'h0020, 0, 32'h0, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0021, 1, 32'h1000_0020, 16'h0020));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 2, 16'h0022, 1, 32'h1000_0020, 16'h0020));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 3, 16'h0023, 1, 32'h1000_0020, 16'h0020));
        tbl.push_back(mk(0, 1, 16'h0040, 1, 0, 16'h0040, 0, 32'h0, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h0041, 1, 32'h1000_0040, 16'h0040));
        tbl.push_back(mk(0, 1, 16'hFFFE, 1, 0, 16'hFFFE, 0, 32'h0, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 16'hFFFF, 1, 32'h1000_FFFE, 16'hFFFE));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 2, 16'h0000, 1, 32'h1000_FFFE, 16'hFFFE));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 3, 16'h0001, 1, 32'h1000_FFFE, 16'hFFFE));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 3, 16'h0002, 1, 32'h1000_FFFF, 16'hFFFF));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 3, 16'h0003, 1, 32'h1000_0000, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 4, 16'h0004, 1, 32'h1000_0000, 16'h0000));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 4, 16'h0004, 1, 32'h1000_0000, 16'h0000));
        tbl.push_back(mk(1, 1, 16'h0077, 0, 0, 16'h0000, 0, 32'h0, 16'h0000));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].f, tbl[i].fa, tbl[i].p);
            chk($sformatf("v%0d.count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d.im_addr", i), 32'(im_addr), 32'(tbl[i].ia));
            chk($sformatf("v%0d.valid", i), 32'(inst_valid), 32'(tbl[i].v));
            chk($sformatf("v%0d.out", i), inst_out, tbl[i].out);
            chk($sformatf("v%0d.pc", i), 32'(inst_pc), 32'(tbl[i].pc));
        end

`ifdef FQ_HALT_DETECT_EN
        mode = 2;
        step(1, 0, 16'h0, 0);
        chk("halt.reset", 32'(halted), 32'h0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 16'h0, 0);
        chk("halt.set", 32'(halted), 32'h1);
        chk("halt.addr", 32'(im_addr), 32'h3);
        chk("halt.count", 32'(count), 32'h3);
        step(0, 0, 16'h0, 0);
        chk("halt.hold_addr", 32'(im_addr), 32'h3);
        chk("halt.hold_count", 32'(count), 32'h3);
        step(0, 0, 16'h0, 1);
        chk("halt.drain1", inst_out, 32'h1000_0001);
        step(0, 0, 16'h0, 1);
        chk("halt.drain2", inst_out, 32'hF000_0000);
        chk("halt.drain2_pc", 32'(inst_pc), 32'h2);
        step(0, 0, 16'h0, 1);
        chk("halt.empty", 32'(inst_valid), 32'h0);
        chk("halt.still", 32'(halted), 32'h1);
        step(0, 1, 16'h0010, 0);
        chk("halt.clear", 32'(halted), 32'h0);
        chk("halt.redirect", 32'(im_addr), 32'h10);
        step(0, 0, 16'h0, 0);
        chk("halt.resume_pc", 32'(inst_pc), 32'h10);
        chk("halt.resume_out", inst_out, 32'h1000_0010);
`endif

        mode = 1;
        step(1, 0, 16'h0, 0);
        chk_model("rnd.reset");
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        f;
            logic [15:0] fa;
            logic        p;
            r = $urandom_range(0, 99) == 0;
            f = $urandom_range(0, 19) == 0;
            fa = $urandom_range(0, 3) == 0 ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            p = $urandom_range(0, 9) < 6;
            step(r, f, fa, p);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
